// File: rtl/rms_pkg.sv
// Shared constants and FSM state type for the ADC sample source and its consumers.
package rms_pkg;

  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_BITS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

endpackage

// File: rtl/adc_sample_source_if.sv
// Bundle of the ADC serial pins and the sample stream handed to the mean/RMS consumer.
interface adc_sample_source_if;
  import rms_pkg::*;

  logic                start;
  logic                adc_miso;
  logic                adc_cs_n;
  logic                adc_sclk;
  logic [SAMPLE_W-1:0] serial_in;
  logic                sample_valid;
  logic                window_last;
  logic                busy;

  modport master (
    input  start, adc_miso,
    output adc_cs_n, adc_sclk, serial_in, sample_valid, window_last, busy
  );

  modport slave (
    output start, adc_miso,
    input  adc_cs_n, adc_sclk, serial_in, sample_valid, window_last, busy
  );
endinterface

// File: rtl/sclk_tick_gen.sv
// Half-period tick for adc_sclk: pulses on the last clk cycle of every CLK_DIV-cycle phase while enabled.
module sclk_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/adc_sample_source.sv
// SPI-style ADC reader: frames 16-bit conversions, delivers the low 12 bits and marks WINDOW_N windows.
// Optional ADC_SAMPLE_SOURCE_OFFSET_EN removes mid-scale, giving two's-complement samples.
module adc_sample_source
  import rms_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned QUIET_CYC = 8,
  parameter int unsigned WINDOW_N  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                adc_miso,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [SAMPLE_W-1:0] serial_in,
  output logic                sample_valid,
  output logic                window_last,
  output logic                busy
);

  localparam int unsigned      WIN_W      = $clog2(WINDOW_N) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_N - 1);
  localparam logic [4:0]       HALF_LAST  = 5'(2 * FRAME_BITS - 1);
  localparam logic [7:0]       QUIET_LAST = 8'(QUIET_CYC - 1);

  state_t                  state, state_nxt;
  logic                    tick, tick_en;
  logic [4:0]              half_cnt;
  logic [7:0]              quiet_cnt;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [WIN_W-1:0]        win_cnt;
  logic [SAMPLE_W-1:0]     sample_nxt;
  logic                    unused_lead_bits;

  assign tick_en = (state == CS_SETUP) || (state == SHIFT);

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = CS_SETUP;
      CS_SETUP: if (tick) state_nxt = SHIFT;
      SHIFT:    if (tick && (half_cnt == HALF_LAST)) state_nxt = DONE;
      DONE:     state_nxt = QUIET;
      QUIET:    if (quiet_cnt == QUIET_LAST) state_nxt = start ? CS_SETUP : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Even half-phases of SHIFT are the sclk-low halves.
  assign adc_cs_n = !tick_en;
  assign adc_sclk = !((state == SHIFT) && !half_cnt[0]);

  assign unused_lead_bits = ^shift_q[FRAME_BITS-1:FRAME_BITS-LEAD_BITS];

`ifdef ADC_SAMPLE_SOURCE_OFFSET_EN
  assign sample_nxt = shift_q[FRAME_BITS-LEAD_BITS-1:0] - 12'd2048;
`else
  assign sample_nxt = shift_q[FRAME_BITS-LEAD_BITS-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt     <= '0;
      quiet_cnt    <= '0;
      shift_q      <= '0;
      serial_in    <= '0;
      sample_valid <= 1'b0;
      window_last  <= 1'b0;
      win_cnt      <= '0;
      busy         <= 1'b0;
    end else begin
      busy         <= (state != IDLE);
      sample_valid <= 1'b0;
      window_last  <= 1'b0;

      if (state != SHIFT) half_cnt <= '0;
      else if (tick)      half_cnt <= half_cnt + 5'd1;

      // Capture on the final cycle of each low phase, just before sclk rises.
      if ((state == SHIFT) && tick && !half_cnt[0])
        shift_q <= {shift_q[FRAME_BITS-2:0], adc_miso};

      if (state != QUIET) quiet_cnt <= '0;
      else                quiet_cnt <= quiet_cnt + 8'd1;

      if (state == DONE) begin
        serial_in    <= sample_nxt;
        sample_valid <= 1'b1;
        if (win_cnt == WIN_LAST) begin
          win_cnt     <= '0;
          window_last <= 1'b1;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_source.sv
// Self-checking bench for adc_sample_source with a behavioural ADC and sample/window reference model.
module tb_adc_sample_source;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned QUIET_CYC = 8;
  localparam int unsigned WINDOW_N  = 8;
  localparam int          LATENCY   = CLK_DIV * 33 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  int   n_samples = 0;

  adc_sample_source_if bus();

  always #5 clk = ~clk;

  adc_sample_source #(
    .CLK_DIV   (CLK_DIV),
    .QUIET_CYC (QUIET_CYC),
    .WINDOW_N  (WINDOW_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (bus.start),
    .adc_miso     (bus.adc_miso),
    .adc_cs_n     (bus.adc_cs_n),
    .adc_sclk     (bus.adc_sclk),
    .serial_in    (bus.serial_in),
    .sample_valid (bus.sample_valid),
    .window_last  (bus.window_last),
    .busy         (bus.busy)
  );

  // ADC model: a frame is latched when cs_n falls; MSB first, next bit after each sclk rise.
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = '0;
  int          bitn = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!bus.adc_cs_n && prev_cs) begin
      if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
      else                    cur_frame = 16'($urandom);
      bitn = 0;
    end else if (bus.adc_cs_n) begin
      bitn = 0;
    end else if (bus.adc_sclk && !prev_sclk) begin
      bitn++;
    end
    prev_cs   = bus.adc_cs_n;
    prev_sclk = bus.adc_sclk;
    bus.adc_miso = (bitn < 16) ? cur_frame[15 - bitn] : 1'b0;
  end

  function automatic logic [11:0] ref_sample(input logic [15:0] frame);
    int v;
    v = int'(frame) % 4096;
`ifdef ADC_SAMPLE_SOURCE_OFFSET_EN
    v = (v + 4096 - 2048) % 4096;
`endif
    return 12'(v);
  endfunction

  function automatic logic ref_window_last(input int count);
    return (count % int'(WINDOW_N)) == 0;
  endfunction

  task automatic do_reset();
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_samples = 0;
    frame_q.delete();
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.adc_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int viol;
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.sample_valid, bus.window_last} !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_ctrl: cs_n/sclk/busy/valid/last got %b expected 11000",
               {bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.sample_valid, bus.window_last});
    end
    n_total++;
    if (bus.serial_in !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_data: serial_in got %h expected 000", bus.serial_in);
    end
    @(negedge clk);
    n_total++;
    if (bus.adc_cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_priority: cs_n got %b expected 1 with rst and start high", bus.adc_cs_n);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    n_samples = 0;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.adc_cs_n || !bus.adc_sclk || bus.busy || bus.sample_valid) viol++;
    end
    n_total++;
    if (viol !== 0) begin
      n_bad++;
      $display("FAIL idle_hold: %0d active cycles got, expected 0", viol);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int lat, rises;
    logic prev;
    frame_q.push_back(16'h0A5C);
    bus.start = 1'b1;
    wait_cs_fall(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_cs_fall: cs_n never fell, expected a falling edge");
      bus.start = 1'b0;
      return;
    end
    lat = 0;
    rises = 0;
    prev = bus.adc_sclk;
    while (!bus.sample_valid && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.adc_sclk && !prev) rises++;
      prev = bus.adc_sclk;
    end
    bus.start = 1'b0;
    if (bus.sample_valid) n_samples++;
    n_total++;
    if (lat !== LATENCY) begin
      n_bad++;
      $display("FAIL single_latency: got %0d cycles expected %0d", lat, LATENCY);
    end
    n_total++;
    if (rises !== 16) begin
      n_bad++;
      $display("FAIL single_sclk_rises: got %0d expected 16", rises);
    end
    n_total++;
    if (bus.serial_in !== ref_sample(16'h0A5C)) begin
      n_bad++;
      $display("FAIL single_data: serial_in got %h expected %h", bus.serial_in, ref_sample(16'h0A5C));
    end
    n_total++;
    if (bus.window_last !== ref_window_last(n_samples)) begin
      n_bad++;
      $display("FAIL single_window_last: got %b expected %b", bus.window_last, ref_window_last(n_samples));
    end
    wait_idle(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_idle: busy stayed high, expected 0");
    end
  endtask

  task automatic test_window();
    logic [15:0] frames[16];
    bit ok;
    int cyc;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      frames[k] = {4'($urandom), (k < 8) ? 12'(k) : 12'($urandom)};
      frame_q.push_back(frames[k]);
    end
    bus.start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_valid(400, ok, cyc);
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL window_timeout: sample %0d missing after %0d cycles, expected a valid", k, cyc);
        break;
      end
      n_samples++;
      if (k == 15) bus.start = 1'b0;
      n_total++;
      if (bus.serial_in !== ref_sample(frames[k])) begin
        n_bad++;
        $display("FAIL window_data[%0d]: got %h expected %h", k, bus.serial_in, ref_sample(frames[k]));
      end
      n_total++;
      if (bus.window_last !== ref_window_last(n_samples)) begin
        n_bad++;
        $display("FAIL window_last[%0d]: got %b expected %b", k, bus.window_last, ref_window_last(n_samples));
      end
    end
    bus.start = 1'b0;
    wait_idle(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL window_idle: busy stayed high, expected 0");
    end
  endtask

  task automatic test_stop_mid();
    logic [15:0] f0, f1;
    bit ok;
    int cyc, rises, falls;
    logic prev;
    do_reset();
    f0 = 16'($urandom);
    f1 = 16'($urandom);
    frame_q.push_back(f0);
    frame_q.push_back(f1);
    bus.start = 1'b1;
    wait_valid(400, ok, cyc);
    n_total++;
    if (!ok || bus.serial_in !== ref_sample(f0)) begin
      n_bad++;
      $display("FAIL stop_first_data: got %h valid=%b expected %h", bus.serial_in, ok, ref_sample(f0));
    end
    wait_cs_fall(ok);
    rises = 0;
    prev = bus.adc_sclk;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      @(negedge clk);
      if (bus.adc_sclk && !prev) rises++;
      prev = bus.adc_sclk;
    end
    bus.start = 1'b0;
    wait_valid(400, ok, cyc);
    n_total++;
    if (!ok || bus.serial_in !== ref_sample(f1)) begin
      n_bad++;
      $display("FAIL stop_second_data: got %h valid=%b expected %h", bus.serial_in, ok, ref_sample(f1));
    end
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc !== int'(QUIET_CYC) + 1) begin
      n_bad++;
      $display("FAIL stop_busy_fall: got %0d cycles expected %0d", cyc, QUIET_CYC + 1);
    end
    falls = 0;
    prev = bus.adc_cs_n;
    repeat (300) begin
      @(negedge clk);
      if (!bus.adc_cs_n && prev) falls++;
      prev = bus.adc_cs_n;
    end
    n_total++;
    if (falls !== 0) begin
      n_bad++;
      $display("FAIL stop_no_third: got %0d cs_n falls expected 0", falls);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] frames[8];
    bit ok;
    int cyc, rises, stray;
    logic prev;
    do_reset();
    bus.start = 1'b1;
    wait_cs_fall(ok);
    rises = 0;
    prev = bus.adc_sclk;
    for (int i = 0; i < 200 && rises < 9; i++) begin
      @(negedge clk);
      if (bus.adc_sclk && !prev) rises++;
      prev = bus.adc_sclk;
    end
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.adc_cs_n, bus.adc_sclk, bus.sample_valid, bus.busy} !== 4'b1100) begin
      n_bad++;
      $display("FAIL abort_ctrl: cs_n/sclk/valid/busy got %b expected 1100",
               {bus.adc_cs_n, bus.adc_sclk, bus.sample_valid, bus.busy});
    end
    rst = 1'b0;
    bus.start = 1'b0;
    n_samples = 0;
    stray = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.sample_valid) stray++;
    end
    n_total++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL abort_no_valid: got %0d valids expected 0", stray);
    end
    for (int k = 0; k < 8; k++) begin
      frames[k] = 16'($urandom);
      frame_q.push_back(frames[k]);
    end
    bus.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid(400, ok, cyc);
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL restart_timeout: sample %0d missing, expected a valid", k);
        break;
      end
      n_samples++;
      if (k == 7) bus.start = 1'b0;
      n_total++;
      if (bus.window_last !== ref_window_last(n_samples) || bus.serial_in !== ref_sample(frames[k])) begin
        n_bad++;
        $display("FAIL restart_sample[%0d]: got last=%b data=%h expected last=%b data=%h", k,
                 bus.window_last, bus.serial_in, ref_window_last(n_samples), ref_sample(frames[k]));
      end
    end
    bus.start = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_boundary_values();
    logic [15:0] frames[2];
    bit ok;
    int cyc;
    do_reset();
    frames[0] = 16'hF000;
    frames[1] = 16'h0FFF;
    frame_q.push_back(frames[0]);
    frame_q.push_back(frames[1]);
    bus.start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_valid(400, ok, cyc);
      if (k == 1) bus.start = 1'b0;
      n_total++;
      if (!ok || bus.serial_in !== ref_sample(frames[k])) begin
        n_bad++;
        $display("FAIL boundary[%0d]: got %h valid=%b expected %h", k, bus.serial_in, ok, ref_sample(frames[k]));
      end
    end
    bus.start = 1'b0;
    wait_idle(ok);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single_frame();
    test_window();
    test_stop_mid();
    test_reset_mid();
    test_boundary_values();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_source.md
ADC_SAMPLE_SOURCE -- requirements
Module: adc_sample_source

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per adc_sclk half-period (legal range 2..255).
REQ-002 SHALL have parameter QUIET_CYC, default 8: clk cycles adc_cs_n is held high between conversions (legal range 1..255).
REQ-003 SHALL have parameter WINDOW_N, default 8: samples per averaging window (legal range 1..65535).
REQ-004 SHALL have port clk, input, 1 bit: single clock. All logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: level-sensitive run enable for continuous conversions.
REQ-007 SHALL have port adc_miso, input, 1 bit: serial data from the ADC.
REQ-008 SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-009 SHALL have port adc_sclk, output, 1 bit: ADC serial clock, idle high.
REQ-010 SHALL have port serial_in, output, 12 bits: parallel sample delivered to the mean/RMS consumer.
REQ-011 SHALL have port sample_valid, output, 1 bit: one-cycle strobe qualifying serial_in.
REQ-012 SHALL have port window_last, output, 1 bit: marks the final sample of a WINDOW_N window.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CS_SETUP, SHIFT, DONE and QUIET.
REQ-015 IDLE with start=1 SHALL go to CS_SETUP on the next edge and drive adc_cs_n=0 from that cycle.
REQ-016 CS_SETUP SHALL last CLK_DIV cycles with adc_sclk=1, then go to SHIFT.
REQ-017 SHIFT SHALL emit 16 adc_sclk periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-018 SHIFT SHALL capture adc_miso into a 16-bit MSB-first shift register in the last clk cycle of each low phase, i.e. on the cycle before adc_sclk rises.
REQ-019 After the 16th high phase the FSM SHALL enter DONE for exactly 1 cycle with adc_cs_n=1.
REQ-020 In DONE, serial_in SHALL take shift[11:0] and sample_valid SHALL be 1; the 4 leading frame bits SHALL be discarded.
REQ-021 serial_in SHALL hold its value until the next DONE.
REQ-022 QUIET SHALL hold adc_cs_n=1 for QUIET_CYC cycles, then go to CS_SETUP if start=1, else to IDLE.
REQ-023 Deasserting start mid-conversion SHALL NOT abort it: the frame completes and is delivered, then the FSM goes to IDLE via QUIET.
REQ-024 Latency from cs_n falling to sample_valid SHALL be CLK_DIV*33+1 cycles (default 133).
REQ-025 A window counter of width clog2(WINDOW_N)+1 SHALL increment on each sample_valid.
REQ-026 window_last SHALL be asserted coincident with the sample_valid of the WINDOW_N-th sample, and the counter SHALL wrap to 0 on that same edge.
REQ-027 With WINDOW_N=1, window_last SHALL equal sample_valid.
REQ-028 start held low SHALL never affect the window count; the count persists across IDLE periods.

Reset
REQ-029 rst=1 SHALL, on the next edge, force state IDLE, adc_cs_n=1, adc_sclk=1, serial_in=0, sample_valid=0, window_last=0, busy=0, window count 0 and shift register 0.
REQ-030 Reset mid-SHIFT SHALL abort the frame without issuing sample_valid.
REQ-031 rst SHALL take priority over start when both are high.

Configuration
REQ-032 With macro ADC_SAMPLE_SOURCE_OFFSET_EN defined, serial_in SHALL be shift[11:0] minus 12'd2048, i.e. mid-scale removed, two's complement, wrapping modulo 2^12.
REQ-033 Without ADC_SAMPLE_SOURCE_OFFSET_EN, serial_in SHALL be raw unsigned shift[11:0].
REQ-034 Timing, window and reset behaviour SHALL be identical with and without ADC_SAMPLE_SOURCE_OFFSET_EN.

Structure
REQ-035 Package rms_pkg SHALL hold SAMPLE_W=12, FRAME_BITS=16, LEAD_BITS=4 and the FSM state enum.
REQ-036 A sub-module sclk_tick_gen SHALL produce the half-period tick from CLK_DIV; the FSM SHALL count ticks and bits.

Verification
REQ-037 Reset, then hold start=0 for 50 cycles -> adc_cs_n=1, adc_sclk=1, busy=0 and no sample_valid.
REQ-038 Defaults, start=1, ADC model returning frame 16'h0A5C -> serial_in=12'hA5C with sample_valid 133 cycles after cs_n falls, and 16 sclk rising edges counted.
REQ-039 start=1 held, with 8 frames of values 0,1,...,7 -> window_last only on the 8th valid; 16 frames -> window_last on the 8th and 16th valids only.
REQ-040 Deassert start during bit 5 of the 2nd frame -> 2nd sample is delivered, then busy falls QUIET_CYC+1 cycles after it and no 3rd cs_n falling edge occurs.
REQ-041 Assert rst during bit 9 of a frame -> next cycle cs_n=1, sclk=1, no sample_valid; after restart the first window_last arrives on the 8th new sample.
REQ-042 With ADC_SAMPLE_SOURCE_OFFSET_EN, data 12'h000 -> serial_in=12'h800, and data 12'hFFF -> serial_in=12'h7FF.
